// File: rtl/rom_pass_scanner_if.sv
// Command/result bundle between the lock FSM (master) and the password ROM scanner (slave).
interface rom_pass_scanner_if #(
   parameter int unsigned DATA_W = 20,
   parameter int unsigned ADDR_W = 3
);
   logic              start;
   logic              mode;
   logic [DATA_W-1:0] key;
   logic              busy;
   logic              word_valid;
   logic [DATA_W-1:0] word_out;
   logic [ADDR_W-1:0] word_idx;
   logic              done;
   logic              found;
   logic [ADDR_W-1:0] match_idx;
   logic [ADDR_W:0]   entry_cnt;

   modport master (
      output start, mode, key,
      input  busy, word_valid, word_out, word_idx, done, found, match_idx, entry_cnt
   );

   modport slave (
      input  start, mode, key,
      output busy, word_valid, word_out, word_idx, done, found, match_idx, entry_cnt
   );
endinterface

// File: rtl/rom_pass_scanner.sv
// Sequences a synchronous password ROM: DUMP streams every entry out, SEARCH looks for
// the latched key and stops at the first hit. Blank (all-zero) entries never match.
module rom_pass_scanner #(
   parameter int unsigned DATA_W  = 20,
   parameter int unsigned ADDR_W  = 3,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned ROM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   rom_pass_scanner_if.slave bus,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q
);
   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t state_q, state_d;
   logic   mode_q, mode_d;
   logic [DATA_W-1:0] key_q, key_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              busy_q, busy_d;
   logic              wvalid_q, wvalid_d;
   logic [DATA_W-1:0] wout_q, wout_d;
   logic [ADDR_W-1:0] widx_q, widx_d;
   logic              done_q, done_d;
   logic              found_q, found_d;
   logic [ADDR_W-1:0] midx_q, midx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Valid/index tags travelling alongside each outstanding ROM read.
   logic [ROM_LAT-1:0]             pipe_v_q, pipe_v_d;
   logic [ROM_LAT-1:0][ADDR_W-1:0] pipe_idx_q, pipe_idx_d;
   logic                           issue;
   logic                           ret_v;
   logic [ADDR_W-1:0]              ret_idx;

   assign ret_v   = pipe_v_q[ROM_LAT-1];
   assign ret_idx = pipe_idx_q[ROM_LAT-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         mode_q     <= 1'b0;
         key_q      <= '0;
         addr_q     <= '0;
         busy_q     <= 1'b0;
         wvalid_q   <= 1'b0;
         wout_q     <= '0;
         widx_q     <= '0;
         done_q     <= 1'b0;
         found_q    <= 1'b0;
         midx_q     <= '0;
         cnt_q      <= '0;
         pipe_v_q   <= '0;
         pipe_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         key_q      <= key_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
         wvalid_q   <= wvalid_d;
         wout_q     <= wout_d;
         widx_q     <= widx_d;
         done_q     <= done_d;
         found_q    <= found_d;
         midx_q     <= midx_d;
         cnt_q      <= cnt_d;
         pipe_v_q   <= pipe_v_d;
         pipe_idx_q <= pipe_idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      key_d    = key_q;
      addr_d   = addr_q;
      busy_d   = busy_q;
      wvalid_d = 1'b0;
      wout_d   = wout_q;
      widx_d   = widx_q;
      done_d   = 1'b0;
      found_d  = found_q;
      midx_d   = midx_q;
      cnt_d    = cnt_q;
      issue    = 1'b0;

      case (state_q)
         IDLE: begin
            addr_d = '0;
            busy_d = 1'b0;
            if (bus.start) begin
               mode_d  = bus.mode;
               key_d   = bus.key;
               found_d = 1'b0;
               midx_d  = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            issue = 1'b1;
            if (addr_q == LAST_ADDR) begin
               addr_d  = '0;
               state_d = DRAIN;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      pipe_v_d[0]   = issue;
      pipe_idx_d[0] = addr_q;
      for (int unsigned k = 1; k < ROM_LAT; k++) begin
         pipe_v_d[k]   = pipe_v_q[k-1];
         pipe_idx_d[k] = pipe_idx_q[k-1];
      end

      // Consume the word whose tag reaches the end of the pipeline this cycle.
      if (ret_v && (state_q == ISSUE || state_q == DRAIN)) begin
         if (!mode_q) begin
            wvalid_d = 1'b1;
            wout_d   = rom_q;
            widx_d   = ret_idx;
            if (rom_q != '0) cnt_d = cnt_q + CNT_W'(1);
            if (ret_idx == LAST_ADDR) begin
               done_d  = 1'b1;
               state_d = DONE;
            end
         end else if (rom_q == key_q && rom_q != '0) begin
            found_d  = 1'b1;
            midx_d   = ret_idx;
            done_d   = 1'b1;
            state_d  = DONE;
            addr_d   = '0;
            pipe_v_d = '0;
         end else if (ret_idx == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = DONE;
         end
      end
   end

   assign rom_addr       = addr_q;
   assign bus.busy       = busy_q;
   assign bus.word_valid = wvalid_q;
   assign bus.word_out   = wout_q;
   assign bus.word_idx   = widx_q;
   assign bus.done       = done_q;
   assign bus.found      = found_q;
   assign bus.match_idx  = midx_q;
   assign bus.entry_cnt  = cnt_q;
endmodule

// File: tb/tb_rom_pass_scanner.sv
// Directed bench: instance A uses a 1-cycle ROM, instance B a 2-cycle ROM, sharing one image.
module tb_rom_pass_scanner;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic        sel;
   logic        start;
   logic        mode;
   logic [19:0] key;
   logic [2:0]  addr_a, addr_b;
   logic [19:0] q_a, q_b, qb1;

   logic [19:0] mem [8] = '{20'h12345, 20'h00000, 20'hABCDE, 20'h00001,
                            20'h00000, 20'hFFFFF, 20'h55555, 20'hAAAAA};

   rom_pass_scanner_if #(.DATA_W(20), .ADDR_W(3)) ifa ();
   rom_pass_scanner_if #(.DATA_W(20), .ADDR_W(3)) ifb ();

   assign ifa.start = start && !sel;
   assign ifa.mode  = mode;
   assign ifa.key   = key;
   assign ifb.start = start && sel;
   assign ifb.mode  = mode;
   assign ifb.key   = key;

   rom_pass_scanner #(.DATA_W(20), .ADDR_W(3), .DEPTH(8), .ROM_LAT(1)) dut_a (
      .clk(clk), .rst(rst_a), .bus(ifa), .rom_addr(addr_a), .rom_q(q_a));
   rom_pass_scanner #(.DATA_W(20), .ADDR_W(3), .DEPTH(8), .ROM_LAT(2)) dut_b (
      .clk(clk), .rst(rst_b), .bus(ifb), .rom_addr(addr_b), .rom_q(q_b));

   always_ff @(posedge clk) begin
      q_a <= mem[addr_a];
      qb1 <= mem[addr_b];
      q_b <= qb1;
   end

   logic        o_busy, o_wv, o_done, o_found;
   logic [19:0] o_wout;
   logic [2:0]  o_widx, o_midx, o_addr;
   logic [3:0]  o_cnt;

   always_comb begin
      o_busy  = sel ? ifb.busy       : ifa.busy;
      o_wv    = sel ? ifb.word_valid : ifa.word_valid;
      o_done  = sel ? ifb.done       : ifa.done;
      o_found = sel ? ifb.found      : ifa.found;
      o_wout  = sel ? ifb.word_out   : ifa.word_out;
      o_widx  = sel ? ifb.word_idx   : ifa.word_idx;
      o_midx  = sel ? ifb.match_idx  : ifa.match_idx;
      o_addr  = sel ? addr_b         : addr_a;
      o_cnt   = sel ? ifb.entry_cnt  : ifa.entry_cnt;
   end

   int    total = 0;
   int    bad   = 0;
   string cur   = "";

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s/%s: got %0h want %0h", cur, tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {o_busy, o_wv, o_done, o_found, o_widx, o_midx, o_cnt} | 32'(o_wout) | 32'(o_addr);
   endfunction

   task automatic run_scan(input string name, input bit s, input bit m, input logic [19:0] k,
                           input bit poke, input int exp_done, input int exp_strobes,
                           input bit exp_found, input int exp_midx, input int exp_cnt);
      int lat, ndone, done_cyc, nstrobe;
      cur      = name;
      lat      = s ? 2 : 1;
      ndone    = 0;
      done_cyc = -1;
      nstrobe  = 0;
      @(posedge clk); #1;
      sel = s; mode = m; key = k; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("busy_c1", 32'(o_busy), 1);
            chk("addr_c1", 32'(o_addr), 0);
         end
         if (c == 2) chk("addr_c2", 32'(o_addr), 1);
         if (o_wv) begin
            chk("widx", 32'(o_widx), 32'(nstrobe));
            if (nstrobe < 8) chk("wdata", 32'(o_wout), 32'(mem[nstrobe]));
            chk("wcycle", 32'(c), 32'(nstrobe + 2 + lat));
            nstrobe++;
         end
         if (o_done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = c;
            chk("found_at_done", 32'(o_found), 32'(exp_found));
            chk("midx_at_done", 32'(o_midx), 32'(exp_midx));
            chk("cnt_at_done", 32'(o_cnt), 32'(exp_cnt));
            chk("busy_at_done", 32'(o_busy), 1);
            if (poke) start = 1'b1;
         end
         if (done_cyc > 0 && c == done_cyc + 1) begin
            chk("busy_after", 32'(o_busy), 0);
            chk("addr_after", 32'(o_addr), 0);
         end
         if (poke && c == 4) begin
            start = 1'b1;
            mode  = ~m;
            key   = 20'h55555;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      chk("done_pulses", 32'(ndone), 1);
      chk("done_cycle", 32'(done_cyc), 32'(exp_done));
      chk("strobes", 32'(nstrobe), 32'(exp_strobes));
      chk("found_held", 32'(o_found), 32'(exp_found));
      chk("midx_held", 32'(o_midx), 32'(exp_midx));
      chk("cnt_held", 32'(o_cnt), 32'(exp_cnt));
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      sel = 1'b0; start = 1'b0; mode = 1'b0; key = '0;

      cur = "reset";
      repeat (5) begin
         @(negedge clk);
         chk("outs_in_reset", all_outs(), 0);
         @(posedge clk);
      end
      #2;
      rst_a = 1'b1; rst_b = 1'b1;
      cur = "idle";
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("outs_idle", all_outs(), 0);
      end

      // name, inst, mode, key, poke, done, strobes, found, midx, cnt
      run_scan("dump_lat1",   1'b0, 1'b0, 20'h00000, 1'b0, 10, 8, 1'b0, 0, 6);
      run_scan("hit_fffff",   1'b0, 1'b1, 20'hFFFFF, 1'b0,  8, 0, 1'b1, 5, 0);
      run_scan("miss_11111",  1'b0, 1'b1, 20'h11111, 1'b0, 10, 0, 1'b0, 0, 0);
      run_scan("zero_key",    1'b0, 1'b1, 20'h00000, 1'b0, 10, 0, 1'b0, 0, 0);
      run_scan("poke_abcde",  1'b0, 1'b1, 20'hABCDE, 1'b1,  5, 0, 1'b1, 2, 0);
      run_scan("hit_first",   1'b0, 1'b1, 20'h12345, 1'b0,  3, 0, 1'b1, 0, 0);
      run_scan("hit_last",    1'b0, 1'b1, 20'hAAAAA, 1'b0, 10, 0, 1'b1, 7, 0);

      // Lat-2 DUMP aborted by reset in cycle 5.
      cur = "abort_lat2";
      @(posedge clk); #1;
      sel = 1'b1; mode = 1'b0; key = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      chk("pre_addr", 32'(o_addr), 4);
      chk("pre_widx", 32'(o_widx), 1);
      chk("pre_cnt", 32'(o_cnt), 1);
      chk("pre_busy", 32'(o_busy), 1);
      rst_b = 1'b0;
      #1;
      chk("outs_on_reset", all_outs(), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("no_done_in_reset", 32'(o_done), 0);
      end
      rst_b = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("quiet_after_reset", all_outs(), 0);
      end

      run_scan("dump_lat2",   1'b1, 1'b0, 20'h00000, 1'b0, 11, 8, 1'b0, 0, 6);
      run_scan("hit_lat2",    1'b1, 1'b1, 20'h55555, 1'b0, 10, 0, 1'b1, 6, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rom_pass_scanner.md
# rom_pass_scanner

Parametrised controller that sequences a synchronous password ROM and either streams every stored entry out (DUMP mode) or searches for an entered key (SEARCH mode), reporting the hit index. It sits between the password ROM and the game lock FSM. It generalises the fixed 8×20-bit password reader with configurable width, depth and ROM read latency, a start/done handshake, early-abort search and blank-entry handling.

## Interface
- DATA_W, 20, password word width in bits
- ADDR_W, 3, ROM address width
- DEPTH, 8, number of entries scanned (2..2^ADDR_W); addresses 0..DEPTH-1
- ROM_LAT, 1, ROM read latency in cycles (1 or 2)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a scan; sampled only in IDLE
- mode  in  1  0 = DUMP, 1 = SEARCH; latched with start
- key  in  DATA_W  search key; latched with start
- rom_addr  out  ADDR_W  registered address to ROM
- rom_q  in  DATA_W  ROM read data
- busy  out  1  high from first issued address through the done cycle
- word_valid  out  1  DUMP: one-cycle strobe per returned entry
- word_out  out  DATA_W  entry data, valid with word_valid
- word_idx  out  ADDR_W  entry address, valid with word_valid
- done  out  1  one-cycle pulse, scan finished
- found  out  1  SEARCH result; held until next accepted start
- match_idx  out  ADDR_W  index of first match; held with found
- entry_cnt  out  ADDR_W+1  DUMP: number of non-zero entries; held until next start

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: rom_addr = 0, busy = 0. On start = 1, latch mode and key, clear found, match_idx and entry_cnt, and go to ISSUE.
- ISSUE: drive rom_addr 0,1,…,DEPTH-1, one per cycle. After DEPTH-1 is issued, go to DRAIN and set rom_addr to 0.
- A ROM_LAT-deep valid/index pipeline tags each address. Returned data is sampled ROM_LAT cycles after its address was driven.
- DRAIN: wait for in-flight words. When the last word is processed, go to DONE.
- DONE lasts one cycle. Assert done, then return to IDLE.
- DUMP mode: for each returned word, register word_out = rom_q, word_idx = tag and word_valid = 1. Increment entry_cnt when the word is non-zero.
- SEARCH mode: compare rom_q with the latched key.
  - On the first equality, set found = 1 and match_idx = tag. Stop issuing, discard in-flight data and go to DONE directly.
  - A word of all zeros denotes an empty slot and never matches. A key of all zeros therefore always misses.
  - word_valid stays 0 in SEARCH mode.
- A miss leaves found = 0 and match_idx = 0 after the full scan.
- start while busy = 1 (including the done cycle) is ignored. mode and key changes during a scan have no effect.
- Reset: all outputs and state clear immediately and asynchronously.
  - rom_addr = 0; busy, word_valid, done and found = 0; word_out, word_idx, match_idx and entry_cnt = 0; FSM = IDLE.
  - Reset mid-scan aborts with no done pulse.

## Timing
- start is sampled high at the end of cycle 0.
  - Cycle 1: busy = 1, rom_addr = 0.
  - Cycle i+1: rom_addr = i.
- DUMP: word_valid for index i is high in cycle i+2+ROM_LAT.
  - done coincides with the last word_valid, in cycle DEPTH+1+ROM_LAT.
  - busy falls in the next cycle.
- SEARCH hit at index i: found, match_idx and done become valid in cycle i+2+ROM_LAT. No further words are processed.
- SEARCH miss: done in cycle DEPTH+1+ROM_LAT.
- Earliest re-accepted start: the cycle after done.
- entry_cnt and found are final in the done cycle.

## Test plan
- Reset and idle: hold rst = 0 for 5 cycles, release mid-cycle, then run 10 idle cycles.
  - Required: rom_addr = 0 and all flags, data outputs and counters = 0 throughout; no done pulse.
- DUMP, DEPTH = 8, ROM_LAT = 1, ROM = {0x12345, 0, 0xABCDE, 0x00001, 0, 0xFFFFF, 0x55555, 0xAAAAA}, start at cycle 0:
  - Required: 8 word_valid strobes in cycles 3–10 with matching data and idx 0–7.
  - Required: done in cycle 10, entry_cnt = 6.
- SEARCH hit, same ROM, key = 0xFFFFF:
  - Required: found = 1, match_idx = 5, done in cycle 8.
  - Required: rom_addr returns to 0 and no further processing occurs.
  - Then SEARCH key = 0x11111: found = 0 and done in cycle 10 of that scan.
- SEARCH with key = 0: found = 0 despite the two blank slots; done after the full scan.
- start pulses during busy and in the done cycle are ignored; a single done pulse occurs per accepted start.
- ROM_LAT = 2 DUMP, then reset asserted at cycle 5 mid-scan:
  - Required: outputs clear immediately with no done pulse.
  - A fresh start afterwards completes with done in cycle 11.
